// File: rtl/counter_run_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : counter_run_arbiter
// Description : Round-robin owner of a shared modulo run-counter; each grant
//               runs the count from 0 to the owner's latched terminal value.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_run_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    input  logic               pause,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic [CW-1:0]      cnt,
    output logic               done,
    output logic               abort,
    output logic [2:0]         owner_id
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [2:0]    r_owner;
    logic [2:0]    r_ptr;
    logic [2:0]    w_win;
    logic [2:0]    w_ptr_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_term;
    logic [CW-1:0] w_len_win;
    logic          r_abort;
    logic          w_any_req;
    logic          w_owner_req;
    logic          w_found;
    logic [7:0]    w_req_ext;
    logic [3:0]    w_idx;

    // Zero-extended copy lets 3-bit indices address any NREQ without range warnings
    assign w_req_ext   = 8'(req);
    assign w_any_req   = |req;
    assign w_owner_req = w_req_ext[r_owner];

    // First set request at or above the pointer, wrapping modulo NREQ
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + 4'(k);
            if (w_idx >= 4'(NREQ)) begin
                w_idx = w_idx - 4'(NREQ);
            end
            if (!w_found && w_req_ext[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
    end

    always_comb begin
        w_len_win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == 3'(i)) begin
                w_len_win = len[i*CW +: CW];
            end
        end
    end

    assign w_ptr_nxt = (w_win == 3'(NREQ - 1)) ? 3'd0 : w_win + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_owner_req) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == r_term) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // cnt is left untouched outside a run so the last value stays observable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_term  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            if (r_state == S_IDLE && w_any_req) begin
                r_owner <= w_win;
                r_ptr   <= w_ptr_nxt;
                r_cnt   <= '0;
                r_term  <= w_len_win;
            end else if (r_state == S_RUN) begin
                if (!w_owner_req) begin
                    r_abort <= 1'b1;
                end else if (r_cnt != r_term && !pause) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_state == S_RUN && r_owner == 3'(i)) begin
                gnt[i] = 1'b1;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign abort    = r_abort;
    assign cnt      = r_cnt;
    assign owner_id = r_owner;

endmodule
`default_nettype wire
